load_store_queue: RTL

//   In-order load/store queue directly downstream of the Execute stage. Accepts memory ops
//   (mem_or_not_mem=1) with the AGU address, store data, destination register and ROB pointer.

---
 rtl/load_store_queue_pkg.sv | 23 ++
 rtl/load_store_queue_fifo_mem.sv | 24 ++
 rtl/load_store_queue.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/load_store_queue_pkg.sv
// Shared types and field widths for the load/store queue.
package load_store_queue_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2,
    LD_DROP = 2'd3
  } lsq_state_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEST_W = 6;

  // Entry packing, LSB first: type(1) | rob | addr | data | dest
  localparam int TYPE_OFS = 0;
  localparam int ROB_OFS  = 1;

  function automatic int entry_w(input int robw);
    return 1 + robw + ADDR_W + DATA_W + DEST_W;
  endfunction

endpackage

// File: rtl/load_store_queue_fifo_mem.sv
// Entry storage: one write port at the tail, async read at the head.
module lsq_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int PTRW  = 3,
  parameter int W     = 77
) (
  input  logic            CLK,
  input  logic            we,
  input  logic [PTRW-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic [PTRW-1:0] raddr,
  output logic [W-1:0]    rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the enqueued entry into the tail slot.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: enqueue from Execute, one outstanding memory
// access at a time, load results forwarded back, stores issued only at commit.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int ROBWIDTH = 6,
  parameter int DEPTH    = 8,
  parameter int PTRW     = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FREEZE,
  input  logic                flush,
  input  logic                enq_valid,
  input  logic                enq_is_load,
  input  logic [ROBWIDTH-1:0] enq_rob,
  input  logic [ADDR_W-1:0]   enq_addr,
  input  logic [DATA_W-1:0]   enq_wdata,
  input  logic [DEST_W-1:0]   enq_dest,
  input  logic                commit_valid,
  input  logic [ROBWIDTH-1:0] commit_rob,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   LS_fwd_data_COM,
  output logic [DEST_W-1:0]   LS_fwd_reg_COM,
  output logic                LS_fwd_data_COM_flag,
  output logic [ROBWIDTH-1:0] ld_rob_out,
  output logic                store_done,
  output logic [ROBWIDTH-1:0] store_done_rob,
  output logic                lsq_full,
  output logic                lsq_empty
);

  typedef struct packed {
    logic [DEST_W-1:0]   dest;
    logic [DATA_W-1:0]   data;
    logic [ADDR_W-1:0]   addr;
    logic [ROBWIDTH-1:0] rob;
    logic                is_load;
  } entry_t;

  localparam int             EW       = entry_w(ROBWIDTH);
  localparam logic [PTRW:0]  FULL_CNT = (PTRW+1)'(DEPTH);

  lsq_state_e          state, state_nxt;
  logic [PTRW-1:0]     head, tail;
  logic [PTRW:0]       count;
  entry_t              head_e, enq_e;
  logic                enq_fire, ack_ok, pop, issue_ld, issue_st;
  logic                ld_ret, st_ret, st_orphan;
  logic [ROBWIDTH-1:0] req_rob;
  logic [DEST_W-1:0]   req_dest;

  assign lsq_full  = (count == FULL_CNT);
  assign lsq_empty = (count == '0);
  assign mem_req   = (state != IDLE);
  assign ack_ok    = mem_ack & mem_req;
  assign enq_fire  = enq_valid & ~FREEZE & ~flush & ~lsq_full;
  assign enq_e     = '{dest: enq_dest, data: enq_wdata, addr: enq_addr,
                       rob: enq_rob, is_load: enq_is_load};

  lsq_fifo_mem #(.DEPTH(DEPTH), .PTRW(PTRW), .W(EW)) u_mem (
    .CLK   (CLK),
    .we    (enq_fire),
    .waddr (tail),
    .wdata (enq_e),
    .raddr (head),
    .rdata (head_e)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, issue decisions and pop. A flush that lands on the same
  // edge as a load ack finishes the access and drops the data.
  always_comb begin
    state_nxt = state;
    issue_ld  = 1'b0;
    issue_st  = 1'b0;
    case (state)
      IDLE: if (!flush && !lsq_empty) begin
        if (head_e.is_load) begin
          issue_ld  = 1'b1;
          state_nxt = LD_WAIT;
        end else if (commit_valid && commit_rob == head_e.rob) begin
          issue_st  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      LD_WAIT: if (ack_ok) state_nxt = IDLE;
               else if (flush) state_nxt = LD_DROP;
      ST_WAIT: if (ack_ok) state_nxt = IDLE;
      LD_DROP: if (ack_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ld_ret = ack_ok && state == LD_WAIT && !flush;
    st_ret = ack_ok && state == ST_WAIT;
    // A store whose entry was flushed away must not pop a newer entry.
    pop    = ack_ok && !flush &&
             (state == LD_WAIT || (state == ST_WAIT && !st_orphan));
  end

  // Head/tail/count; flush wins over enqueue and pop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + PTRW'(1);
      if (pop)      head <= head + PTRW'(1);
      case ({enq_fire, pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Request fields latched at issue and held while mem_req is up.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_rob   <= '0;
      req_dest  <= '0;
      st_orphan <= 1'b0;
    end else begin
      if (issue_ld || issue_st) begin
        mem_we    <= issue_st;
        mem_addr  <= head_e.addr;
        mem_wdata <= head_e.data;
        req_rob   <= head_e.rob;
        req_dest  <= head_e.dest;
      end
      if (issue_st)                        st_orphan <= 1'b0;
      else if (flush && state == ST_WAIT)  st_orphan <= 1'b1;
    end
  end

  // Completion outputs: one-cycle load forward and store-done pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      LS_fwd_data_COM      <= '0;
      LS_fwd_reg_COM       <= '0;
      LS_fwd_data_COM_flag <= 1'b0;
      ld_rob_out           <= '0;
      store_done           <= 1'b0;
      store_done_rob       <= '0;
    end else begin
      LS_fwd_data_COM_flag <= ld_ret;
      store_done           <= st_ret;
      if (ld_ret) begin
        LS_fwd_data_COM <= mem_rdata;
        LS_fwd_reg_COM  <= req_dest;
        ld_rob_out      <= req_rob;
      end
      if (st_ret) store_done_rob <= req_rob;
    end
  end

endmodule
